memory_interface_unit: RTL and testbench
========================================

Name: memory_interface_unit

Overview:
Responder end of the iu_miu_if handshake. Accepts one byte-wide load or store request from the instruction unit and services it against an internal byte-addressed data memory, with programmable read and write wait states. Returns a single-cycle mem_done with registered read data. Provides a side debug/preload port so testbenches and boot logic can load and inspect memory.

Parameters:
ADDR_W, system_widths_pkg::ADDR_W, width of mem_addr
DEPTH, 256, number of bytes in the internal memory; valid addresses are 0..DEPTH-1
READ_WAIT, 2, wait-state cycles inserted before a read commits (0..15)
WRITE_WAIT, 1, wait-state cycles inserted before a write commits (0..15)

Ports:
clk  input  1  clock
resetN  input  1  asynchronous active-low reset
miu  modport  iu_miu_if.miu  in: mem_req, mem_we, mem_addr[ADDR_W-1:0], mem_write[7:0]; out: mem_done, mem_read[7:0]
dbg_we  input  1  debug byte write strobe
dbg_addr  input  ADDR_W  debug address
dbg_wdata  input  8  debug write data
dbg_rdata  output  8  combinational mem[dbg_addr]; 8'h00 if dbg_addr >= DEPTH
miu_busy_flag  output  1  high in WAIT and RESP
oob_flag  output  1  one-cycle pulse, coincident with mem_done, for an out-of-range access

Behaviour:
- Reset (resetN = 0, asynchronous): state IDLE; req_q = 0; mem_done = 0; mem_read = 8'h00; oob_flag = 0; all memory bytes = 8'h00; wait counter = 0.
- req_q registers mem_req every cycle in every state. A request is accepted only on a rising edge: mem_req = 1 and req_q = 0 while in IDLE.
- The initiator holds mem_req high until it samples mem_done, then drops it. Level-held mem_req after completion must never start a second access.
- States:
  - IDLE: on an accepted request, capture mem_addr, mem_we and mem_write. Load cnt = WRITE_WAIT if mem_we, else READ_WAIT. Go to WAIT.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0, commit the access and go to RESP.
  - RESP: mem_done = 1 for exactly this one cycle, then go to IDLE.
- Latency: the capture edge is E0. mem_done is high in the cycle after edge E0+W+1, where W is the wait count for the access type.
- Commit, read: mem_read <= mem[addr]. mem_read holds its value until the next read commits; writes do not change it.
- Commit, write: mem[addr] <= captured mem_write.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read returns 8'h00.
  - oob_flag pulses together with mem_done.
  - mem_done is always issued, so the initiator never hangs.
- mem_addr, mem_we and mem_write are ignored after the capture edge. mem_req falling mid-access does not abort; the access completes and mem_done still pulses.
- Debug port:
  - dbg_we writes mem[dbg_addr] <= dbg_wdata on any cycle, in any state. Out-of-range debug writes are ignored.
  - If a debug write and a miu write commit to the same address on the same edge, the miu write wins.
- Reset mid-access: the pending access is abandoned, with no commit and no mem_done. After reset the block returns to IDLE.
- miu_busy_flag = state in {WAIT, RESP}.

Test Plan:
1. Defaults, reset, dbg write mem[0x10]=0xA5, then read request addr 0x10 with mem_req held high until done -> mem_done is a single pulse in the cycle after edge E0+3; mem_read=0xA5; oob_flag=0.
2. Write 0x3C to addr 0x20 -> mem_done in the cycle after edge E0+2; dbg_rdata@0x20=0x3C; a following read of 0x20 returns 0x3C; mem_read unchanged between the write and that read.
3. mem_req held high for 10 cycles after mem_done, then low for 2 cycles, then high -> only one mem_done during the hold; the new rising edge starts a second access.
4. DEPTH=128: write 0x77 to addr 0x90 -> mem_done and oob_flag pulse together, memory unchanged. Then read addr 0x90 -> mem_read=0x00, oob_flag pulses again.
5. resetN pulsed low during WAIT of a write of 0x55 to addr 0x05 -> no mem_done; mem[0x05]=0x00; state IDLE; next request serviced normally.
6. Integration with instruction_unit: LDR rt=3 from 0x10 (0xA5), then STR r3 to 0x11 -> regfile r3=0x000000A5, mem[0x11]=0xA5, instruction_done_flag pulses once per instruction.

Source files
------------

// File: rtl/memory_interface_unit.sv
// Responder end of the IU/MIU handshake: one byte load/store per mem_req rising edge,
// with wait states, a single-cycle mem_done and a debug/preload port. The miu-side
// signals of iu_miu_if are presented as flat ports.
module memory_interface_unit #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_write,
    output logic              mem_done,
    output logic [7:0]        mem_read,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_wdata,
    output logic [7:0]        dbg_rdata,
    output logic              miu_busy_flag,
    output logic              oob_flag
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] RD_CNT = 4'(READ_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WRITE_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             req_q;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             oob_q, oob_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       mem_q [DEPTH];
    logic             commit_wr;
    logic             dbg_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            oob_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= mem_req;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            oob_q   <= oob_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        oob_d   = oob_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Only a rising edge of mem_req starts an access; a held level does not.
                if (mem_req && !req_q) begin
                    idx_d   = mem_addr[IDX_W-1:0];
                    we_d    = mem_we;
                    wdata_d = mem_write;
                    oob_d   = !in_range(mem_addr);
                    cnt_d   = mem_we ? WR_CNT : RD_CNT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (!we_q) rdata_d = oob_q ? 8'h00 : mem_q[idx_q];
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit_wr = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !oob_q;
    assign dbg_ok    = in_range(dbg_addr);

    // The miu write is assigned last so it wins over a same-edge debug write.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            if (dbg_we && dbg_ok) mem_q[dbg_addr[IDX_W-1:0]] <= dbg_wdata;
            if (commit_wr)        mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_done      = (state_q == RESP);
    assign mem_read      = rdata_q;
    assign oob_flag      = (state_q == RESP) && oob_q;
    assign miu_busy_flag = (state_q == WAIT) || (state_q == RESP);
    assign dbg_rdata     = dbg_ok ? mem_q[dbg_addr[IDX_W-1:0]] : 8'h00;
endmodule

// File: tb/tb_memory_interface_unit.sv
// Directed bench for memory_interface_unit (DEPTH=128): the driver queues the expected
// response of every access and a monitor checks it whenever mem_done appears.
module tb_memory_interface_unit;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       mem_req = 1'b0, mem_we = 1'b0;
    logic [7:0] mem_addr = '0, mem_write = '0;
    logic       mem_done;
    logic [7:0] mem_read;
    logic       dbg_we = 1'b0;
    logic [7:0] dbg_addr = '0, dbg_wdata = '0;
    logic [7:0] dbg_rdata;
    logic       miu_busy_flag, oob_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       we;
        logic [7:0] rd;
        logic       oob;
        string      name;
    } exp_t;
    exp_t sb[$];

    memory_interface_unit #(.ADDR_W(8), .DEPTH(128), .READ_WAIT(2), .WRITE_WAIT(1)) dut (
        .clk(clk), .resetN(resetN),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_done(mem_done), .mem_read(mem_read),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
        .miu_busy_flag(miu_busy_flag), .oob_flag(oob_flag)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expected response per mem_done and checks oob_flag stays low otherwise.
    always @(negedge clk) begin
        if (resetN) begin
            if (mem_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(mem_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.we) chk({e.name, "_rdata"}, 32'(mem_read), 32'(e.rd));
                    chk({e.name, "_oob"}, 32'(oob_flag), 32'(e.oob));
                    $display("resp %s we=%0d rdata=%02h oob=%0d", e.name, e.we, mem_read, oob_flag);
                end
            end else if (oob_flag) begin
                chk("oob_without_done", 32'(oob_flag), 32'd0);
            end
        end
    end

    task automatic check_dbg(input logic [7:0] addr, input logic [7:0] exp, input string name);
        @(negedge clk);
        dbg_addr = addr;
        #1;
        chk(name, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic dbg_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    task automatic do_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd, input logic exp_oob,
                             input bit hold, input bit collide, input string name);
        exp_t e;
        int   n;
        int   lat;
        lat = we ? 3 : 4;
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_write = wdata;
        e.we = we; e.rd = exp_rd; e.oob = exp_oob; e.name = name;
        sb.push_back(e);
        $display("issue %s we=%0d addr=%02h wdata=%02h", name, we, addr, wdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Captured fields must be immune to later changes on the request bus.
                chk({name, "_busy_wait"}, 32'(miu_busy_flag), 32'd1);
                mem_we = ~we; mem_addr = ~addr; mem_write = ~wdata;
            end
            if (collide && n == 2) begin
                dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = 8'h99;
            end
        end while (!mem_done && n < 50);
        dbg_we = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_busy_resp"}, 32'(miu_busy_flag), 32'd1);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (i == 0) chk({name, "_hold_single"}, 32'(mem_done), 32'd0);
            end
            chk({name, "_hold_idle"}, 32'(miu_busy_flag), 32'd0);
            mem_req = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            mem_req = 1'b0;
            @(negedge clk);
            chk({name, "_single_pulse"}, 32'(mem_done), 32'd0);
            chk({name, "_idle"}, 32'(miu_busy_flag), 32'd0);
        end
    endtask

    initial begin
        #3;
        chk("rst_done", 32'(mem_done), 32'd0);
        chk("rst_read", 32'(mem_read), 32'd0);
        chk("rst_oob", 32'(oob_flag), 32'd0);
        chk("rst_busy", 32'(miu_busy_flag), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        check_dbg(8'h10, 8'h00, "rst_mem10");

        // Preload then read back through the handshake.
        dbg_write(8'h10, 8'hA5);
        check_dbg(8'h10, 8'hA5, "dbg_wr10");
        do_access(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, "rd10");

        // Write, then confirm memory and that mem_read held its old value.
        do_access(1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, "wr20");
        check_dbg(8'h20, 8'h3C, "dbg_rd20");
        chk("read_held_after_wr", 32'(mem_read), 32'hA5);
        do_access(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, "rd20");

        // Level-held request: one response only, then a new rising edge works.
        do_access(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, "rd10_hold");
        do_access(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, "rd20_again");

        // Out of range: 0x90 aliases 0x10 in the low bits, which must stay intact.
        do_access(1'b1, 8'h90, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, "wr90_oob");
        check_dbg(8'h10, 8'hA5, "oob_no_alias");
        check_dbg(8'h90, 8'h00, "dbg_rd90_oob");
        do_access(1'b0, 8'h90, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "rd90_oob");
        chk("oob_read_zero", 32'(mem_read), 32'h00);

        // Debug write and miu write land on the same edge and address.
        do_access(1'b1, 8'h30, 8'h66, 8'h00, 1'b0, 1'b0, 1'b1, "wr30_collide");
        check_dbg(8'h30, 8'h66, "collide_miu_wins");
        dbg_write(8'h7F, 8'h5A);
        do_access(1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, "rd7f_top");

        // Reset in the WAIT state of a write abandons it.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h05; mem_write = 8'h55;
        $display("issue wr05_reset we=1 addr=05 wdata=55");
        @(negedge clk);
        chk("pre_reset_busy", 32'(miu_busy_flag), 32'd1);
        resetN = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("mid_reset_busy", 32'(miu_busy_flag), 32'd0);
        chk("mid_reset_done", 32'(mem_done), 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        check_dbg(8'h05, 8'h00, "reset_no_commit");
        chk("post_reset_busy", 32'(miu_busy_flag), 32'd0);
        do_access(1'b1, 8'h05, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, "wr05_after");
        do_access(1'b0, 8'h05, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0, "rd05_after");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
